// File: rtl/cc_rowscan_pkg.sv
// Shared types and default sizes for the row-scan reducer.
package cc_rowscan_pkg;

  // Scan controller states
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StScan = 2'b01,
    StDone = 2'b10
  } state_e;

  // Default matrix geometry: 8 columns by 8 rows
  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefRows      = 8;
  localparam int unsigned DefIdxWidth  = 3;

endpackage

// File: rtl/cc_row_reduce.sv
// Combinational single-row reduction: pass-through OR contribution plus an all-ones flag.
module cc_row_reduce
  import cc_rowscan_pkg::*;
#(
  parameter int unsigned WIDTH = DefDataWidth
) (
  input  logic [WIDTH-1:0] row_i,
  output logic [WIDTH-1:0] or_bits_o,
  output logic             all_ones_o
);

  // A single row contributes its own bits to the column OR; full when every bit is set
  always_comb begin
    or_bits_o  = row_i;
    all_ones_o = &row_i;
  end

endmodule

// File: rtl/cc_row_scan_reduce.sv
// Sequential row scanner: ORs NUMBER_ROWS rows one per clock and flags completely full rows.
// Optional feature: define CC_ROWSCAN_FULLCOUNT_EN to add a full-row count output.
module cc_row_scan_reduce
  import cc_rowscan_pkg::*;
#(
  parameter int unsigned NUMBER_DATAWIDTH = DefDataWidth,
  parameter int unsigned NUMBER_ROWS      = DefRows,
  parameter int unsigned NUMBER_IDXWIDTH  = DefIdxWidth
) (
  input  logic                                  CC_ROWSCAN_CLOCK_50,
  input  logic                                  CC_ROWSCAN_RESET_InLow,
  input  logic [NUMBER_ROWS*NUMBER_DATAWIDTH-1:0] CC_ROWSCAN_rows_InBUS,
  input  logic                                  CC_ROWSCAN_start_In,
  output logic                                  CC_ROWSCAN_busy_Out,
  output logic                                  CC_ROWSCAN_done_Out,
  output logic [NUMBER_DATAWIDTH-1:0]           CC_ROWSCAN_or_OutBUS,
  output logic [NUMBER_ROWS-1:0]                CC_ROWSCAN_fullmask_OutBUS
`ifdef CC_ROWSCAN_FULLCOUNT_EN
  ,
  output logic [NUMBER_IDXWIDTH:0]              CC_ROWSCAN_fullcount_OutBUS
`endif
);

  localparam int unsigned CntW = NUMBER_IDXWIDTH + 1;
  localparam logic [NUMBER_IDXWIDTH-1:0] LastIdx = NUMBER_IDXWIDTH'(NUMBER_ROWS - 1);

  state_e                                state_q, state_d;
  logic [NUMBER_IDXWIDTH-1:0]            idx_q, idx_d;
  logic [NUMBER_ROWS*NUMBER_DATAWIDTH-1:0] rows_q, rows_d;
  logic [NUMBER_DATAWIDTH-1:0]           acc_or_q, acc_or_d;
  logic [NUMBER_ROWS-1:0]                acc_full_q, acc_full_d;
  logic [NUMBER_DATAWIDTH-1:0]           res_or_q, res_or_d;
  logic [NUMBER_ROWS-1:0]                res_full_q, res_full_d;
`ifdef CC_ROWSCAN_FULLCOUNT_EN
  logic [CntW-1:0]                       acc_cnt_q, acc_cnt_d;
  logic [CntW-1:0]                       res_cnt_q, res_cnt_d;
`endif

  logic [NUMBER_DATAWIDTH-1:0] cur_row;
  logic [NUMBER_DATAWIDTH-1:0] cur_or;
  logic                        cur_full;
  logic                        last_row;

  // Index never exceeds LastIdx, so this select stays inside the snapshot
  assign cur_row  = rows_q[idx_q*NUMBER_DATAWIDTH +: NUMBER_DATAWIDTH];
  assign last_row = (idx_q == LastIdx);

  cc_row_reduce #(
    .WIDTH (NUMBER_DATAWIDTH)
  ) u_row_reduce (
    .row_i      (cur_row),
    .or_bits_o  (cur_or),
    .all_ones_o (cur_full)
  );

  // FSM state register
  always_ff @(posedge CC_ROWSCAN_CLOCK_50 or negedge CC_ROWSCAN_RESET_InLow) begin
    if (!CC_ROWSCAN_RESET_InLow) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: start is only honoured in idle, so requests while busy are dropped
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (CC_ROWSCAN_start_In) state_d = StScan;
      StScan:  if (last_row) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    CC_ROWSCAN_busy_Out = 1'b0;
    CC_ROWSCAN_done_Out = 1'b0;
    unique case (state_q)
      StIdle:  ;
      StScan:  CC_ROWSCAN_busy_Out = 1'b1;
      StDone: begin
        CC_ROWSCAN_busy_Out = 1'b1;
        CC_ROWSCAN_done_Out = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next-state: snapshot on start, accumulate per row, publish after the last row
  always_comb begin
    idx_d      = idx_q;
    rows_d     = rows_q;
    acc_or_d   = acc_or_q;
    acc_full_d = acc_full_q;
    res_or_d   = res_or_q;
    res_full_d = res_full_q;
`ifdef CC_ROWSCAN_FULLCOUNT_EN
    acc_cnt_d  = acc_cnt_q;
    res_cnt_d  = res_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (CC_ROWSCAN_start_In) begin
          rows_d     = CC_ROWSCAN_rows_InBUS;
          idx_d      = '0;
          acc_or_d   = '0;
          acc_full_d = '0;
`ifdef CC_ROWSCAN_FULLCOUNT_EN
          acc_cnt_d  = '0;
`endif
        end
      end
      StScan: begin
        acc_or_d          = acc_or_q | cur_or;
        acc_full_d[idx_q] = cur_full;
`ifdef CC_ROWSCAN_FULLCOUNT_EN
        acc_cnt_d         = acc_cnt_q + CntW'(cur_full);
`endif
        if (last_row) begin
          // Results take the accumulators including the final row in the same edge
          res_or_d   = acc_or_d;
          res_full_d = acc_full_d;
`ifdef CC_ROWSCAN_FULLCOUNT_EN
          res_cnt_d  = acc_cnt_d;
`endif
        end else begin
          idx_d = idx_q + NUMBER_IDXWIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset mid-scan clears everything so no done pulse follows
  always_ff @(posedge CC_ROWSCAN_CLOCK_50 or negedge CC_ROWSCAN_RESET_InLow) begin
    if (!CC_ROWSCAN_RESET_InLow) begin
      idx_q      <= '0;
      rows_q     <= '0;
      acc_or_q   <= '0;
      acc_full_q <= '0;
      res_or_q   <= '0;
      res_full_q <= '0;
`ifdef CC_ROWSCAN_FULLCOUNT_EN
      acc_cnt_q  <= '0;
      res_cnt_q  <= '0;
`endif
    end else begin
      idx_q      <= idx_d;
      rows_q     <= rows_d;
      acc_or_q   <= acc_or_d;
      acc_full_q <= acc_full_d;
      res_or_q   <= res_or_d;
      res_full_q <= res_full_d;
`ifdef CC_ROWSCAN_FULLCOUNT_EN
      acc_cnt_q  <= acc_cnt_d;
      res_cnt_q  <= res_cnt_d;
`endif
    end
  end

  assign CC_ROWSCAN_or_OutBUS       = res_or_q;
  assign CC_ROWSCAN_fullmask_OutBUS = res_full_q;
`ifdef CC_ROWSCAN_FULLCOUNT_EN
  assign CC_ROWSCAN_fullcount_OutBUS = res_cnt_q;
`endif

endmodule
